// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: device/command byte codes and the
// command scheduler state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_RESEND     = 8'hFE;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_NEXT,
    ST_FINISH
  } sched_state_t;

endpackage

// File: rtl/ps2_rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester that was not
// served last wins; the pointer moves only when a command completes.
module ps2_rr_arb2 (
  input  logic clk6x,
  input  logic resetn,
  input  logic req_a,
  input  logic req_b,
  input  logic upd,
  input  logic upd_b,
  output logic win_b,
  output logic any_req
);

  logic last_b;

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      last_b <= 1'b0;
    end else if (upd) begin
      last_b <= upd_b;
    end
  end

  assign any_req = req_a | req_b;
  assign win_b   = (req_a && req_b) ? !last_b : req_b;

endmodule

// File: rtl/ps2_kbd_cmd_sched.sv
// PS/2 keyboard host command scheduler: arbitrates two command sources onto
// one transmit path, handles ACK/resend/timeout retries and forwards scancodes.
module ps2_kbd_cmd_sched
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT_US = 20000,
  parameter int MAX_RETRY      = 3,
  parameter int TO_W           = 15
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       ck1us,
  input  logic       a_req,
  input  logic       a_len2,
  input  logic [7:0] a_b0,
  input  logic [7:0] a_b1,
  output logic       a_gnt,
  output logic       a_done,
  output logic       a_err,
  input  logic       b_req,
  input  logic       b_len2,
  input  logic [7:0] b_b0,
  input  logic [7:0] b_b1,
  output logic       b_gnt,
  output logic       b_done,
  output logic       b_err,
  output logic [7:0] tx_byte,
  output logic       tx_start,
  input  logic       tx_done,
  input  logic       tx_nak,
  input  logic [7:0] rx_byte,
  input  logic       rx_v,
  output logic [7:0] kb_byte,
  output logic       kb_v,
  output logic       busy
);

  localparam int              RT_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(ACK_TIMEOUT_US);
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRY);

  sched_state_t    state, state_nx;
  logic            owner_b, len2, idx, err_f;
  logic [7:0]      cb0, cb1;
  logic [RT_W-1:0] retry;
  logic [TO_W-1:0] to_cnt;
  logic            win_b, any_req, fin_upd;
  logic            ack_rx, res_rx, to_hit, retry_ok, retry_ev, consume;

  ps2_rr_arb2 u_arb (
    .clk6x   (clk6x),
    .resetn  (resetn),
    .req_a   (a_req),
    .req_b   (b_req),
    .upd     (fin_upd),
    .upd_b   (owner_b),
    .win_b   (win_b),
    .any_req (any_req)
  );

  // An ACK always beats a coincident timeout; tx_nak beats tx_done.
  always_comb begin
    ack_rx   = rx_v && (rx_byte == PS2_ACK);
    res_rx   = rx_v && (rx_byte == PS2_RESEND);
    to_hit   = (to_cnt >= TO_LIM);
    retry_ok = (retry < RT_MAX);
    retry_ev = 1'b0;
    consume  = 1'b0;
    case (state)
      ST_WAIT_TX:  retry_ev = tx_nak;
      ST_WAIT_ACK: begin
        retry_ev = !ack_rx && (res_rx || to_hit);
        consume  = ack_rx || res_rx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:     if (any_req) state_nx = ST_LOAD;
      ST_LOAD:     state_nx = ST_SEND;
      ST_SEND:     state_nx = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (retry_ev)     state_nx = retry_ok ? ST_SEND : ST_FINISH;
        else if (tx_done) state_nx = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_rx)        state_nx = ST_NEXT;
        else if (retry_ev) state_nx = retry_ok ? ST_SEND : ST_FINISH;
      end
      ST_NEXT:     state_nx = (len2 && !idx) ? ST_SEND : ST_FINISH;
      ST_FINISH:   state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    a_gnt   = (state == ST_LOAD) && !owner_b;
    b_gnt   = (state == ST_LOAD) && owner_b;
    a_done  = (state == ST_FINISH) && !owner_b && !err_f;
    a_err   = (state == ST_FINISH) && !owner_b && err_f;
    b_done  = (state == ST_FINISH) && owner_b && !err_f;
    b_err   = (state == ST_FINISH) && owner_b && err_f;
    fin_upd = (state == ST_FINISH);
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      owner_b  <= 1'b0;
      len2     <= 1'b0;
      cb0      <= 8'h00;
      cb1      <= 8'h00;
      idx      <= 1'b0;
      retry    <= '0;
      err_f    <= 1'b0;
      to_cnt   <= '0;
      tx_byte  <= 8'h00;
      tx_start <= 1'b0;
      kb_byte  <= 8'h00;
      kb_v     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_start <= (state == ST_SEND);
      busy     <= (state_nx != ST_IDLE);
      kb_v     <= rx_v && !consume;
      if (rx_v && !consume) kb_byte <= rx_byte;
      case (state)
        ST_IDLE:     if (any_req) owner_b <= win_b;
        ST_LOAD: begin
          len2  <= owner_b ? b_len2 : a_len2;
          cb0   <= owner_b ? b_b0 : a_b0;
          cb1   <= owner_b ? b_b1 : a_b1;
          idx   <= 1'b0;
          retry <= '0;
          err_f <= 1'b0;
        end
        ST_SEND:     tx_byte <= idx ? cb1 : cb0;
        ST_WAIT_TX:  to_cnt <= '0;
        ST_WAIT_ACK: if (ck1us && !to_hit) to_cnt <= to_cnt + 1'b1;
        ST_NEXT: begin
          if (len2 && !idx) begin
            idx   <= 1'b1;
            retry <= '0;
          end
        end
        default: ;
      endcase
      if (retry_ev) begin
        if (retry_ok) retry <= retry + 1'b1;
        else          err_f <= 1'b1;
      end
    end
  end

endmodule
